mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single slow off-chip memory port between the I-cache and D-cache miss/writeback engines of the pipelined RISC-V core.
- Sits between the two caches and the memory model, and sequences one block transaction at a time.
- Its cache-facing handshakes match the memory interface the caches already drive, so each cache sees a dedicated memory.
- The core's global stall (ICACHE_stall || DCACHE_stall) covers all arbitration delay.

Parameters:
ADDR_W, 28, block address width (byte address [31:4])
DATA_W, 128, block data width (4 words)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
I_mem_read  in  1  I-cache block read request, held until I_mem_ready
I_mem_addr  in  ADDR_W  I-cache block address
I_mem_rdata  out  DATA_W  block returned to I-cache
I_mem_ready  out  1  one-cycle completion pulse to I-cache
D_mem_read  in  1  D-cache block read request, held until D_mem_ready
D_mem_write  in  1  D-cache block write (writeback) request, held until D_mem_ready
D_mem_addr  in  ADDR_W  D-cache block address
D_mem_wdata  in  DATA_W  D-cache writeback data
D_mem_rdata  out  DATA_W  block returned to D-cache
D_mem_ready  out  1  one-cycle completion pulse to D-cache
mem_read  out  1  memory read strobe, held for the whole transaction
mem_write  out  1  memory write strobe, held for the whole transaction
mem_addr  out  ADDR_W  memory block address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completion pulse

Behaviour:
- Clocking and reset: single clock clk. rst_n is synchronous, active-low, sampled on posedge clk.
- Reset values: state=IDLE; all outputs 0, including both rdata buses.
- All outputs are registered.
- States:
  - IDLE
  - GNT_I
  - GNT_D
  - DONE
- IDLE:
  - D request pending (D_mem_read|D_mem_write) -> GNT_D. D has fixed priority because the D miss is the older instruction.
  - Else I_mem_read -> GNT_I.
  - Else stay in IDLE.
  - On the transition edge, latch mem_addr, mem_wdata and mem_read/mem_write from the winner.
  - Latency: memory strobe is visible 1 cycle after the request is first seen in IDLE.
- GNT_x:
  - Hold mem_read/mem_write, mem_addr and mem_wdata stable.
  - Ignore every other input change.
  - When mem_ready=1:
    - Clear both strobes on the next edge.
    - Capture mem_rdata into the owner's rdata register (write transactions leave rdata unchanged).
    - Pulse the owner's ready for exactly 1 cycle.
    - Go to DONE.
- DONE:
  - Lasts 1 cycle, with the owner's ready=1 and no strobe.
  - The requester samples ready and drops its request in this cycle.
  - Next state is IDLE. This keeps a stale held request from being re-granted.
- Total overhead: 2 cycles beyond memory latency per transaction (grant + DONE).
- rdata registers hold their last value until the next read completion for that port.
- D_mem_read and D_mem_write asserted together is illegal. The block treats it as a write only, and the read is not served.
- A request that arrives while another transaction is active waits. It is never dropped. The other port's ready stays 0 until its own transaction.
- A mem_ready that arrives in IDLE or DONE is ignored.
- Reset mid-transaction: return to IDLE with strobes cleared next edge. The memory transaction is abandoned and no ready is issued.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- Defined:
  - A 1-bit last_owner register (reset = I) gives priority in IDLE to the port that was not last granted.
  - The priority flip applies only when both ports are requesting; a lone requester is always granted.
  - last_owner updates on entry to GNT_x.
- Undefined: fixed D>I priority; no last_owner register.

Decomposition:
- Package mem_arbiter_pkg holds:
  - state enum/localparams (IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2, DONE=2'd3)
  - ADDR_W and DATA_W defaults
  - owner encoding (OWN_I=0, OWN_D=1)
- One sub-module is natural: mem_arbiter_pick, the combinational winner selection (fixed or RR) from the two requests and last_owner.
- The FSM and registered datapath stay in the top module.

Test Plan:
1. I_mem_read=1, addr=0x0000010, memory returns 0xDEADBEEF_... after 5 cycles -> mem_read rises 1 cycle after the request; I_mem_ready pulses once, 1 cycle after mem_ready, with I_mem_rdata equal to the returned data; D outputs stay 0.
2. I_mem_read and D_mem_write (addr 0x0000020, wdata 0x1111...) asserted in the same cycle -> D served first with mem_write=1 and mem_wdata=0x1111...; mem_read for I is issued only after D's DONE cycle; each ready pulses exactly once.
3. Back-to-back: D requests 3 reads, each dropped on ready and re-raised the next cycle -> 3 distinct transactions, never two strobes at once, exactly one DONE cycle between them.
4. rst_n=0 while in GNT_D with mem_read=1 -> next edge: mem_read=0, state IDLE, no D_mem_ready; a fresh request after reset completes normally.
5. D_mem_read=D_mem_write=1 -> only mem_write asserted; D_mem_rdata unchanged at completion.
6. With MEM_ARBITER_RR_EN, both ports requesting continuously -> grants alternate D,I,D,I; without the macro, D is granted every time D requests.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D-cache to memory arbiter.
// Optional round-robin priority is enabled with MEM_ARBITER_RR_EN.
package mem_arbiter_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 28;
    localparam int unsigned DEFAULT_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic owner_t;

    localparam owner_t OWN_I = 1'b0;
    localparam owner_t OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection between the I-cache and D-cache requests.
// Fixed D>I priority by default; MEM_ARBITER_RR_EN alternates on contention.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t last_owner,
    output logic   valid,
    output owner_t owner
);

`ifndef MEM_ARBITER_RR_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        valid = i_req | d_req;
        owner = d_req ? OWN_D : OWN_I;
`ifdef MEM_ARBITER_RR_EN
        // Only contention flips priority; a lone requester always wins.
        if (i_req && d_req) begin
            owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block-wide memory port between the I-cache and D-cache, one transaction at a time.
// Build with MEM_ARBITER_RR_EN for round-robin priority instead of fixed D>I.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I_mem_read,
    input  logic [ADDR_W-1:0] I_mem_addr,
    output logic [DATA_W-1:0] I_mem_rdata,
    output logic              I_mem_ready,
    input  logic              D_mem_read,
    input  logic              D_mem_write,
    input  logic [ADDR_W-1:0] D_mem_addr,
    input  logic [DATA_W-1:0] D_mem_wdata,
    output logic [DATA_W-1:0] D_mem_rdata,
    output logic              D_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_e              state_q, state_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_ready_q, i_ready_d;
    logic                d_ready_q, d_ready_d;

    logic                pick_valid;
    owner_t              pick_owner;
    owner_t              last_owner;

    mem_arbiter_pick u_pick (
        .i_req      (I_mem_read),
        .d_req      (D_mem_read | D_mem_write),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .owner      (pick_owner)
    );

`ifdef MEM_ARBITER_RR_EN
    owner_t last_owner_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_owner_q <= OWN_I;
        end else if (state_q == IDLE && pick_valid) begin
            last_owner_q <= pick_owner;
        end
    end

    assign last_owner = last_owner_q;
`else
    assign last_owner = OWN_I;
`endif

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    if (pick_owner == OWN_D) begin
                        state_d     = GNT_D;
                        mem_addr_d  = D_mem_addr;
                        mem_wdata_d = D_mem_wdata;
                        mem_write_d = D_mem_write;
                        // Read+write together is served as a write only.
                        mem_read_d  = D_mem_read & ~D_mem_write;
                    end else begin
                        state_d     = GNT_I;
                        mem_addr_d  = I_mem_addr;
                        mem_wdata_d = '0;
                        mem_write_d = 1'b0;
                        mem_read_d  = 1'b1;
                    end
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ready) begin
                    state_d     = DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (state_q == GNT_D) begin
                        d_ready_d = 1'b1;
                        if (mem_read_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        i_ready_d = 1'b1;
                        if (mem_read_q) begin
                            i_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            DONE: begin
                // Forced return to IDLE so a still-held stale request is not re-granted.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign I_mem_rdata = i_rdata_q;
    assign D_mem_rdata = d_rdata_q;
    assign I_mem_ready = i_ready_q;
    assign D_mem_ready = d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model, memory model and directed tests.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW  = 28;
    localparam int DW  = 128;
    localparam int LAT = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          I_mem_read = 1'b0;
    logic [AW-1:0] I_mem_addr = '0;
    logic [DW-1:0] I_mem_rdata;
    logic          I_mem_ready;
    logic          D_mem_read = 1'b0;
    logic          D_mem_write = 1'b0;
    logic [AW-1:0] D_mem_addr = '0;
    logic [DW-1:0] D_mem_wdata = '0;
    logic [DW-1:0] D_mem_rdata;
    logic          D_mem_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .I_mem_read  (I_mem_read),
        .I_mem_addr  (I_mem_addr),
        .I_mem_rdata (I_mem_rdata),
        .I_mem_ready (I_mem_ready),
        .D_mem_read  (D_mem_read),
        .D_mem_write (D_mem_write),
        .D_mem_addr  (D_mem_addr),
        .D_mem_wdata (D_mem_wdata),
        .D_mem_rdata (D_mem_rdata),
        .D_mem_ready (D_mem_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mem_store [logic [AW-1:0]];
    string         grant_log[$];

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return {4{4'h0, a}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endtask

    function automatic string log_str();
        string s;
        s = "";
        foreach (grant_log[i]) s = {s, grant_log[i]};
        return s;
    endfunction

    // Memory-model controls
    bit spur = 1'b0;
    bit dbl  = 1'b0;
    bit dbl_left = 1'b0;
    int mcnt = 0;

    // Transaction-level model state
    int            phase = 0;   // 0 free, 1 transaction in flight, 2 completion cycle
    bit            t_d, t_wr;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic [DW-1:0] exp_i_rd = '0;
    logic [DW-1:0] exp_d_rd = '0;
    bit            rr_last = 1'b0;
    logic          p_rst = 1'b0, p_ir = 1'b0, p_dr = 1'b0, p_dw = 1'b0, p_mr = 1'b0;
    logic [AW-1:0] p_ia = '0, p_da = '0;
    logic [DW-1:0] p_dwd = '0;

    always @(negedge clk) begin
        logic e_rd, e_wr, e_ir, e_dr;
        bit   w;
        e_rd = 1'b0;
        e_wr = 1'b0;
        e_ir = 1'b0;
        e_dr = 1'b0;
        if (!p_rst) begin
            phase    = 0;
            rr_last  = 1'b0;
            exp_i_rd = '0;
            exp_d_rd = '0;
            chk("rst_mem_addr", mem_addr, '0);
            chk("rst_mem_wdata", mem_wdata, '0);
        end else begin
            case (phase)
                0: begin
                    if (p_ir || p_dr || p_dw) begin
                        w = p_dr || p_dw;
`ifdef MEM_ARBITER_RR_EN
                        if (p_ir && (p_dr || p_dw)) w = !rr_last;
`endif
                        rr_last = w;
                        t_d     = w;
                        t_wr    = w && p_dw;
                        t_addr  = w ? p_da : p_ia;
                        t_wdata = p_dwd;
                        phase   = 1;
                    end
                end
                1: begin
                    if (p_mr) begin
                        if (!t_wr) begin
                            if (t_d) exp_d_rd = mem_val(t_addr);
                            else     exp_i_rd = mem_val(t_addr);
                        end
                        e_ir  = !t_d;
                        e_dr  = t_d;
                        phase = 2;
                    end
                end
                default: phase = 0;
            endcase
            if (phase == 1) begin
                e_rd = !t_wr;
                e_wr = t_wr;
            end
        end
        chk("mem_read", mem_read, e_rd);
        chk("mem_write", mem_write, e_wr);
        chk("I_mem_ready", I_mem_ready, e_ir);
        chk("D_mem_ready", D_mem_ready, e_dr);
        chk("I_mem_rdata", I_mem_rdata, exp_i_rd);
        chk("D_mem_rdata", D_mem_rdata, exp_d_rd);
        if (e_rd || e_wr) chk("mem_addr", mem_addr, t_addr);
        if (e_wr) chk("mem_wdata", mem_wdata, t_wdata);

        // Memory model: fixed latency, optional stretched or spurious ready.
        if (mem_ready && dbl_left) begin
            dbl_left = 1'b0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
        end else if (spur && !(mem_read || mem_write)) begin
            spur      = 1'b0;
            mem_ready = 1'b1;
            mem_rdata = '1;
        end else if (mem_read || mem_write) begin
            mcnt++;
            if (mcnt == LAT) begin
                mcnt      = 0;
                mem_ready = 1'b1;
                dbl_left  = dbl;
                dbl       = 1'b0;
                if (mem_write) mem_store[mem_addr] = mem_wdata;
                else           mem_rdata = mem_val(mem_addr);
            end
        end else begin
            mcnt = 0;
        end

        p_rst = rst_n;
        p_ir  = I_mem_read;
        p_ia  = I_mem_addr;
        p_dr  = D_mem_read;
        p_dw  = D_mem_write;
        p_da  = D_mem_addr;
        p_dwd = D_mem_wdata;
        p_mr  = mem_ready;
    end

    task automatic wait_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic i_reads(input logic [AW-1:0] a, input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            I_mem_addr = a + AW'(k);
            I_mem_read = 1'b1;
            t = 0;
            do begin
                wait_cyc();
                t++;
            end while (!I_mem_ready && t < 300);
            if (!I_mem_ready) begin
                n_cmp++;
                n_bad++;
                $display("FAIL I_timeout: no I_mem_ready after %0d cycles", t);
            end
            I_mem_read = 1'b0;
            grant_log.push_back("I");
            if (k + 1 < n) wait_cyc();
        end
    endtask

    task automatic d_txn(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            D_mem_addr  = a + AW'(k);
            D_mem_wdata = wd;
            D_mem_read  = rd;
            D_mem_write = wr;
            t = 0;
            do begin
                wait_cyc();
                t++;
            end while (!D_mem_ready && t < 300);
            if (!D_mem_ready) begin
                n_cmp++;
                n_bad++;
                $display("FAIL D_timeout: no D_mem_ready after %0d cycles", t);
            end
            D_mem_read  = 1'b0;
            D_mem_write = 1'b0;
            grant_log.push_back("D");
            if (k + 1 < n) wait_cyc();
        end
    endtask

    initial begin
        int t;
        mem_store[28'h10] = {4{32'hDEADBEEF}};
        repeat (3) wait_cyc();
        chk("reset_I_rdata", I_mem_rdata, '0);
        rst_n = 1'b1;
        wait_cyc();

        // 1: single I read, strobe one cycle after the request
        I_mem_addr = 28'h10;
        I_mem_read = 1'b1;
        wait_cyc();
        chk("t1_strobe_latency", mem_read, 1'b1);
        t = 0;
        while (!I_mem_ready && t < 300) begin
            wait_cyc();
            t++;
        end
        chk("t1_I_ready", I_mem_ready, 1'b1);
        chk("t1_I_rdata", I_mem_rdata, {4{32'hDEADBEEF}});
        chk("t1_D_rdata", D_mem_rdata, '0);
        I_mem_read = 1'b0;
        repeat (3) wait_cyc();

        // 2: simultaneous I read and D write, D first
        grant_log.delete();
        fork
            i_reads(28'h30, 1);
            d_txn(1'b0, 1'b1, 28'h20, {4{32'h11111111}}, 1);
        join
        chk_str("t2_order", log_str(), "DI");
        chk("t2_mem_store", mem_store[28'h20], {4{32'h11111111}});
        chk("t2_I_rdata", I_mem_rdata, {4{32'h00000030}});
        repeat (3) wait_cyc();

        // 3: three back-to-back D reads
        grant_log.delete();
        d_txn(1'b1, 1'b0, 28'h40, '0, 3);
        chk_str("t3_order", log_str(), "DDD");
        chk("t3_D_rdata", D_mem_rdata, {4{32'h00000042}});

        // Spurious mem_ready while idle must be ignored
        repeat (2) wait_cyc();
        spur = 1'b1;
        repeat (4) wait_cyc();
        chk("spur_D_rdata", D_mem_rdata, {4{32'h00000042}});
        chk("spur_I_rdata", I_mem_rdata, {4{32'h00000030}});

        // 4: reset while D read is in flight
        D_mem_addr = 28'h70;
        D_mem_read = 1'b1;
        t = 0;
        while (!mem_read && t < 20) begin
            wait_cyc();
            t++;
        end
        chk("t4_granted", mem_read, 1'b1);
        wait_cyc();
        rst_n      = 1'b0;
        D_mem_read = 1'b0;
        wait_cyc();
        chk("t4_strobe_cleared", mem_read, 1'b0);
        chk("t4_no_D_ready", D_mem_ready, 1'b0);
        rst_n = 1'b1;
        repeat (2) wait_cyc();
        d_txn(1'b1, 1'b0, 28'h50, '0, 1);
        chk("t4_D_rdata", D_mem_rdata, {4{32'h00000050}});
        chk("t4_I_rdata", I_mem_rdata, '0);
        repeat (2) wait_cyc();

        // 5: illegal read+write served as write; stretched mem_ready into DONE
        dbl = 1'b1;
        d_txn(1'b1, 1'b1, 28'h60, {4{32'h22222222}}, 1);
        repeat (3) wait_cyc();
        chk("t5_D_rdata", D_mem_rdata, {4{32'h00000050}});
        chk("t5_mem_store", mem_store[28'h60], {4{32'h22222222}});

        // 6: both ports contending continuously after a fresh reset
        rst_n = 1'b0;
        wait_cyc();
        rst_n = 1'b1;
        wait_cyc();
        grant_log.delete();
        fork
            i_reads(28'h80, 2);
            d_txn(1'b1, 1'b0, 28'h90, '0, 2);
        join
`ifdef MEM_ARBITER_RR_EN
        chk_str("t6_order", log_str(), "DIDI");
`else
        chk_str("t6_order", log_str(), "DDII");
`endif
        chk("t6_I_rdata", I_mem_rdata, {4{32'h00000081}});
        chk("t6_D_rdata", D_mem_rdata, {4{32'h00000091}});
        repeat (3) wait_cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
